// File: rtl/inst_sequencer.sv
//==============================================================================
// Module      : inst_sequencer
// Description : Upstream sequencer for instdecode. Holds the instruction
//               register and the cycle counter, advances the counter from the
//               decoder's icyc/rcyc/scyc strobes, and latches/prioritises
//               reset, NMI and IRQ requests. A pending request forces INT_OP
//               into the instruction register at the opcode-fetch decision.
//
// Parameters  : INT_OP - opcode forced into inst when servicing int/reset
//               CYC_W  - cycle counter width (wraps modulo 2**CYC_W)
//
// Ports       : clk      - system clock, all state on rising edge
//               clr      - synchronous active-high reset
//               rdy      - 1 = advance, 0 = freeze inst/cycle
//               databus  - opcode sampled at end of cycle 0
//               icyc     - decoder: increment cycle
//               rcyc     - decoder: cycle back to 0
//               scyc     - decoder: hold cycle
//               sinst    - decoder: interrupt serviced
//               irqdis   - status I flag, masks irq
//               irq_in   - raw IRQ request (level)
//               nmi_in   - raw NMI request (rising edge)
//               inst     - instruction register
//               cycle    - cycle counter
//               clr_o    - reset pending
//               nmi_o    - NMI pending, masked by reset pending
//               irq_o    - unmasked IRQ, below reset and NMI
//               sync     - high in cycle 0
//
// Config      : INSTSEQ_SYNC_EN - when defined, irq_in/nmi_in pass through a
//               2-flop synchroniser before use.
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module inst_sequencer #(
    parameter logic [7:0] INT_OP = 8'h00,
    parameter int         CYC_W  = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             rdy,
    input  logic [7:0]       databus,
    input  logic             icyc,
    input  logic             rcyc,
    input  logic             scyc,
    input  logic             sinst,
    input  logic             irqdis,
    input  logic             irq_in,
    input  logic             nmi_in,
    output logic [7:0]       inst,
    output logic [CYC_W-1:0] cycle,
    output logic             clr_o,
    output logic             nmi_o,
    output logic             irq_o,
    output logic             sync
);

    localparam logic [CYC_W-1:0] c_CYC_ZERO = '0;
    localparam logic [CYC_W-1:0] c_CYC_ONE  = {{(CYC_W-1){1'b0}}, 1'b1};

    logic             irq_s;
    logic             nmi_s;
    logic             w_fetch;

    logic [7:0]       inst_q,     inst_d;
    logic [CYC_W-1:0] cycle_q,    cycle_d;
    logic             rst_pend_q, rst_pend_d;
    logic             nmi_pend_q, nmi_pend_d;
    logic             nmi_prev_q, nmi_prev_d;

`ifdef INSTSEQ_SYNC_EN
    // Two-stage synchronisers; bit 1 is the stage used by the core logic.
    logic [1:0] irq_sync_q, irq_sync_d;
    logic [1:0] nmi_sync_q, nmi_sync_d;

    always_comb begin
        irq_sync_d = {irq_sync_q[0], irq_in};
        nmi_sync_d = {nmi_sync_q[0], nmi_in};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            irq_sync_q <= 2'b00;
            nmi_sync_q <= 2'b00;
        end else begin
            irq_sync_q <= irq_sync_d;
            nmi_sync_q <= nmi_sync_d;
        end
    end

    assign irq_s = irq_sync_q[1];
    assign nmi_s = nmi_sync_q[1];
`else
    assign irq_s = irq_in;
    assign nmi_s = nmi_in;
`endif

    // Opcode-fetch / service decision point: cycle 0 while the bus is ready.
    assign w_fetch = rdy & (cycle_q == c_CYC_ZERO);

    always_comb begin
        inst_d     = inst_q;
        cycle_d    = cycle_q;
        rst_pend_d = rst_pend_q;
        nmi_pend_d = nmi_pend_q;
        nmi_prev_d = nmi_s;        // tracks the pin every edge, even when stalled

        if (rdy) begin
            if (rcyc) begin
                cycle_d = c_CYC_ZERO;
            end else if (!scyc && icyc) begin
                cycle_d = cycle_q + c_CYC_ONE;
            end
        end

        // With sinst the INT_OP sequence is already running, so inst is kept.
        if (w_fetch && icyc && !sinst) begin
            inst_d = (rst_pend_q || nmi_pend_q || irq_o) ? INT_OP : databus;
        end

        // Only the highest-priority latched flag is retired; irq is a level.
        if (w_fetch && sinst) begin
            if (rst_pend_q) begin
                rst_pend_d = 1'b0;
            end else if (nmi_pend_q) begin
                nmi_pend_d = 1'b0;
            end
        end

        // Set after clear so an edge arriving on the service edge is not lost.
        if (nmi_s && !nmi_prev_q) begin
            nmi_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            inst_q     <= INT_OP;
            cycle_q    <= c_CYC_ZERO;
            rst_pend_q <= 1'b1;
            nmi_pend_q <= 1'b0;
            nmi_prev_q <= 1'b0;
        end else begin
            inst_q     <= inst_d;
            cycle_q    <= cycle_d;
            rst_pend_q <= rst_pend_d;
            nmi_pend_q <= nmi_pend_d;
            nmi_prev_q <= nmi_prev_d;
        end
    end

    assign inst  = inst_q;
    assign cycle = cycle_q;
    assign clr_o = rst_pend_q;
    assign nmi_o = nmi_pend_q & ~rst_pend_q;
    assign irq_o = irq_s & ~irqdis & ~rst_pend_q & ~nmi_pend_q;
    assign sync  = (cycle_q == c_CYC_ZERO);

endmodule

`default_nettype wire

// File: tb/tb_inst_sequencer.sv
//==============================================================================
// Module      : tb_inst_sequencer
// Description : Self-checking bench for inst_sequencer. Directed scenarios
//               check fixed expected values; a randomized phase checks every
//               output each cycle against a behavioural model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_inst_sequencer;

    localparam logic [7:0] c_INT = 8'h00;
`ifdef INSTSEQ_SYNC_EN
    localparam int c_NMI_LAT = 3;
`else
    localparam int c_NMI_LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       clr, rdy, icyc, rcyc, scyc, sinst, irqdis, irq_in, nmi_in;
    logic [7:0] databus;
    logic [7:0] inst;
    logic [2:0] cycle;
    logic       clr_o, nmi_o, irq_o, sync;

    int total = 0;
    int bad   = 0;

    inst_sequencer #(.INT_OP(8'h00), .CYC_W(3)) dut (
        .clk     (clk),
        .clr     (clr),
        .rdy     (rdy),
        .databus (databus),
        .icyc    (icyc),
        .rcyc    (rcyc),
        .scyc    (scyc),
        .sinst   (sinst),
        .irqdis  (irqdis),
        .irq_in  (irq_in),
        .nmi_in  (nmi_in),
        .inst    (inst),
        .cycle   (cycle),
        .clr_o   (clr_o),
        .nmi_o   (nmi_o),
        .irq_o   (irq_o),
        .sync    (sync)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] m_inst;
    int         m_cyc;
    bit         m_rst, m_nmi, m_prev;
    bit [1:0]   m_nmi_h, m_irq_h;

    function automatic bit m_nmi_s();
`ifdef INSTSEQ_SYNC_EN
        return m_nmi_h[1];
`else
        return nmi_in;
`endif
    endfunction

    function automatic bit m_irq_s();
`ifdef INSTSEQ_SYNC_EN
        return m_irq_h[1];
`else
        return irq_in;
`endif
    endfunction

    function automatic bit m_irq();
        return m_irq_s() && !irqdis && !m_rst && !m_nmi;
    endfunction

    task automatic model_step();
        bit ns, irq_now, at_fetch;
        ns       = m_nmi_s();
        irq_now  = m_irq();
        at_fetch = rdy && (m_cyc == 0);
        if (clr) begin
            m_inst = c_INT; m_cyc = 0; m_rst = 1; m_nmi = 0; m_prev = 0;
            m_nmi_h = 2'b00; m_irq_h = 2'b00;
        end else begin
            if (at_fetch && icyc && !sinst)
                m_inst = (m_rst || m_nmi || irq_now) ? c_INT : databus;
            if (at_fetch && sinst) begin
                if (m_rst) m_rst = 0;
                else       m_nmi = 0;
            end
            if (ns && !m_prev) m_nmi = 1;
            m_prev = ns;
            if (rdy) begin
                if (rcyc)               m_cyc = 0;
                else if (!scyc && icyc) m_cyc = (m_cyc + 1) % 8;
            end
            m_nmi_h = {m_nmi_h[0], nmi_in};
            m_irq_h = {m_irq_h[0], irq_in};
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr = 0; rdy = 1; icyc = 0; rcyc = 0; scyc = 0; sinst = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle(); clr = 1; irqdis = 1; irq_in = 0; nmi_in = 0; databus = 8'h55;
        tick();
        total++; if (inst !== 8'h00) begin bad++; $display("FAIL reset_inst got=%h want=00", inst); end
        total++; if (cycle !== 3'd0) begin bad++; $display("FAIL reset_cycle got=%0d want=0", cycle); end
        total++; if ({clr_o, nmi_o, irq_o, sync} !== 4'b1001) begin
            bad++; $display("FAIL reset_flags got=%b want=1001", {clr_o, nmi_o, irq_o, sync}); end
        idle(); icyc = 1; sinst = 1;
        tick();
        total++; if (inst !== 8'h00) begin bad++; $display("FAIL rstsvc_inst got=%h want=00", inst); end
        total++; if (clr_o !== 1'b0) begin bad++; $display("FAIL rstsvc_clr_o got=%b want=0", clr_o); end
        total++; if (cycle !== 3'd1) begin bad++; $display("FAIL rstsvc_cycle got=%0d want=1", cycle); end
        idle(); rcyc = 1;
        tick();
    endtask

    task automatic test_fetch();
        idle(); icyc = 1; databus = 8'hA9;
        tick();
        total++; if (inst !== 8'hA9) begin bad++; $display("FAIL fetch_inst got=%h want=a9", inst); end
        total++; if (cycle !== 3'd1) begin bad++; $display("FAIL fetch_c1 got=%0d want=1", cycle); end
        databus = 8'h11;
        tick();
        total++; if (cycle !== 3'd2) begin bad++; $display("FAIL fetch_c2 got=%0d want=2", cycle); end
        tick();
        total++; if (cycle !== 3'd3) begin bad++; $display("FAIL fetch_c3 got=%0d want=3", cycle); end
        total++; if (inst !== 8'hA9) begin bad++; $display("FAIL fetch_hold got=%h want=a9", inst); end
        icyc = 0; rcyc = 1;
        tick();
        total++; if (cycle !== 3'd0 || sync !== 1'b1) begin
            bad++; $display("FAIL fetch_rcyc got=%0d/%b want=0/1", cycle, sync); end
    endtask

    task automatic test_nmi();
        idle(); nmi_in = 1; #1;
        total++; if (nmi_o !== 1'b0) begin bad++; $display("FAIL nmi_early got=%b want=0", nmi_o); end
        for (int i = 0; i < c_NMI_LAT - 1; i++) tick();
        total++; if (nmi_o !== 1'b0) begin bad++; $display("FAIL nmi_lat got=%b want=0", nmi_o); end
        tick();
        total++; if (nmi_o !== 1'b1) begin bad++; $display("FAIL nmi_set got=%b want=1", nmi_o); end
        icyc = 1; databus = 8'hEA;
        tick();
        total++; if (inst !== 8'h00) begin bad++; $display("FAIL nmi_force got=%h want=00", inst); end
        idle(); rcyc = 1;
        tick();
        idle(); icyc = 1; sinst = 1;
        tick();
        total++; if (nmi_o !== 1'b0) begin bad++; $display("FAIL nmi_clear got=%b want=0", nmi_o); end
        total++; if (inst !== 8'h00) begin bad++; $display("FAIL nmi_svc_inst got=%h want=00", inst); end
        idle(); rcyc = 1;
        tick(); tick();
        total++; if (nmi_o !== 1'b0) begin bad++; $display("FAIL nmi_level got=%b want=0", nmi_o); end
        nmi_in = 0;
        tick(); tick(); tick();
    endtask

    task automatic test_irq();
        idle(); irq_in = 1; irqdis = 1;
        tick(); tick();
        icyc = 1; databus = 8'h4C;
        tick();
        total++; if (inst !== 8'h4C) begin bad++; $display("FAIL irq_masked_inst got=%h want=4c", inst); end
        total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b want=0", irq_o); end
        idle(); rcyc = 1;
        tick();
        idle(); irqdis = 0; #1;
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_unmask got=%b want=1", irq_o); end
        icyc = 1; databus = 8'h77;
        tick();
        total++; if (inst !== 8'h00) begin bad++; $display("FAIL irq_force got=%h want=00", inst); end
        idle(); rcyc = 1;
        tick();
        total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL irq_level got=%b want=1", irq_o); end
        irq_in = 0; irqdis = 1;
        tick(); tick(); tick();
    endtask

    task automatic test_stall();
        idle(); icyc = 1; databus = 8'hB1;
        tick(); tick();
        total++; if (cycle !== 3'd2 || inst !== 8'hB1) begin
            bad++; $display("FAIL stall_setup got=%0d/%h want=2/b1", cycle, inst); end
        rdy = 0; nmi_in = 1; databus = 8'h3E;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (cycle !== 3'd2 || inst !== 8'hB1) begin
                bad++; $display("FAIL stall_frozen[%0d] got=%0d/%h want=2/b1", i, cycle, inst); end
        end
        total++; if (nmi_o !== 1'b1) begin bad++; $display("FAIL stall_nmi got=%b want=1", nmi_o); end
        idle(); rcyc = 1;
        tick();
        idle(); icyc = 1; sinst = 1;
        tick();
        nmi_in = 0; idle(); rcyc = 1;
        tick(); tick(); tick();
    endtask

    task automatic test_clr_mid();
        idle(); icyc = 1; databus = 8'h6D;
        for (int i = 0; i < 5; i++) tick();
        total++; if (cycle !== 3'd5 || inst !== 8'h6D) begin
            bad++; $display("FAIL clrmid_setup got=%0d/%h want=5/6d", cycle, inst); end
        clr = 1;
        tick();
        total++; if (inst !== 8'h00 || cycle !== 3'd0) begin
            bad++; $display("FAIL clrmid_state got=%h/%0d want=00/0", inst, cycle); end
        total++; if ({clr_o, nmi_o, sync} !== 3'b101) begin
            bad++; $display("FAIL clrmid_flags got=%b want=101", {clr_o, nmi_o, sync}); end
        idle(); icyc = 1; sinst = 1;
        tick();
        total++; if (clr_o !== 1'b0) begin bad++; $display("FAIL clrmid_svc got=%b want=0", clr_o); end
        idle(); rcyc = 1;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            clr     = ($urandom_range(0, 49) == 0);
            rdy     = ($urandom_range(0, 4) != 0);
            icyc    = ($urandom_range(0, 3) != 0);
            rcyc    = ($urandom_range(0, 5) == 0);
            scyc    = ($urandom_range(0, 7) == 0);
            sinst   = ($urandom_range(0, 3) == 0);
            databus = 8'($urandom);
            if ($urandom_range(0, 9) == 0) nmi_in = ~nmi_in;
            if ($urandom_range(0, 9) == 0) irq_in = ~irq_in;
            if ($urandom_range(0, 19) == 0) irqdis = ~irqdis;
            tick();
            total++; if (inst !== m_inst) begin
                bad++; $display("FAIL rand_inst[%0d] got=%h want=%h", n, inst, m_inst); end
            total++; if (cycle !== 3'(m_cyc)) begin
                bad++; $display("FAIL rand_cycle[%0d] got=%0d want=%0d", n, cycle, m_cyc); end
            total++; if (clr_o !== m_rst) begin
                bad++; $display("FAIL rand_clr_o[%0d] got=%b want=%b", n, clr_o, m_rst); end
            total++; if (nmi_o !== (m_nmi && !m_rst)) begin
                bad++; $display("FAIL rand_nmi_o[%0d] got=%b want=%b", n, nmi_o, m_nmi && !m_rst); end
            total++; if (irq_o !== m_irq()) begin
                bad++; $display("FAIL rand_irq_o[%0d] got=%b want=%b", n, irq_o, m_irq()); end
            total++; if (sync !== (m_cyc == 0)) begin
                bad++; $display("FAIL rand_sync[%0d] got=%b want=%b", n, sync, m_cyc == 0); end
        end
    endtask

    initial begin
        idle(); irqdis = 1; irq_in = 0; nmi_in = 0; databus = 8'h00;
        test_reset();
        test_fetch();
        test_nmi();
        test_irq();
        test_stall();
        test_clr_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

`default_nettype wire
